// File: rtl/pdm_cic_decimator.sv
// Single-channel PDM-to-PCM core: STAGES-order CIC decimator followed by a gain multiply,
// arithmetic shift and saturation. One comb stage is evaluated per clock to share a subtractor.
module pdm_cic_decimator #(
    parameter int unsigned STAGES      = 4,
    parameter int unsigned DECIM_WIDTH = 8,
    parameter int unsigned GAIN_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned OUT_SHIFT   = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [DECIM_WIDTH-1:0] decimation_factor_i,
    input  logic [GAIN_WIDTH-1:0]  gain_i,
    input  logic                   pdm_valid_i,
    input  logic                   pdm_bit_i,
    output logic [DATA_WIDTH-1:0]  pcm_sample_o,
    output logic                   pcm_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int unsigned ACC_WIDTH  = 2 + STAGES * DECIM_WIDTH;
    localparam int unsigned PROD_WIDTH = ACC_WIDTH + GAIN_WIDTH + 1;
    localparam int unsigned CIDX_WIDTH = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic signed [PROD_WIDTH-1:0] SAT_MAX =
        {{(PROD_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUMULATE,
        S_COMB,
        S_SCALE,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [ACC_WIDTH-1:0]   integ     [STAGES];
    logic [ACC_WIDTH-1:0]   integ_nxt [STAGES];
    logic [ACC_WIDTH-1:0]   comb_dly  [STAGES];
    logic [ACC_WIDTH-1:0]   snapshot;
    logic [DECIM_WIDTH-1:0] dec_cnt;
    logic [DECIM_WIDTH-1:0] r_latched;
    logic [DECIM_WIDTH-1:0] r_eff;
    logic [CIDX_WIDTH-1:0]  comb_idx;

    logic                         flush;
    logic                         accept;
    logic                         dec_point;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [PROD_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]        sat;

    assign flush     = rst_i || !enable_i;
    assign r_eff     = (decimation_factor_i < DECIM_WIDTH'(2)) ? DECIM_WIDTH'(2) : decimation_factor_i;
    assign accept    = pdm_valid_i && (state != S_IDLE);
    assign dec_point = accept && (dec_cnt == r_latched - DECIM_WIDTH'(1));

    // Cascaded integrators: every stage sees the current bit in the same cycle
    always_comb begin
        logic [ACC_WIDTH-1:0] carry;
        carry = pdm_bit_i ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}};
        for (int k = 0; k < STAGES; k++) begin
            carry        = integ[k] + carry;
            integ_nxt[k] = carry;
        end
    end

    // Gain, shift and clamp of the finished comb result held in snapshot
    always_comb begin
        prod    = $signed({{(GAIN_WIDTH+1){snapshot[ACC_WIDTH-1]}}, snapshot})
                * $signed({{(ACC_WIDTH+1){1'b0}}, gain_i});
        shifted = prod >>> OUT_SHIFT;
        sat     = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (enable_i) state_nxt = S_ACCUMULATE;
            S_ACCUMULATE: if (dec_point) state_nxt = S_COMB;
            S_COMB:       if (comb_idx == CIDX_WIDTH'(STAGES - 1)) state_nxt = S_SCALE;
            S_SCALE:      state_nxt = S_OUTPUT;
            S_OUTPUT:     state_nxt = S_ACCUMULATE;
            default:      state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: integrators, decimation counter, serial comb and registered outputs
    always_ff @(posedge clk_i) begin
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
            end
            snapshot     <= '0;
            dec_cnt      <= '0;
            r_latched    <= r_eff;
            comb_idx     <= '0;
            pcm_sample_o <= '0;
            pcm_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            pcm_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= (state_nxt == S_COMB) || (state_nxt == S_SCALE) || (state_nxt == S_OUTPUT);
            if (state == S_IDLE) begin
                r_latched <= r_eff;
            end
            if (accept) begin
                for (int k = 0; k < STAGES; k++) begin
                    integ[k] <= integ_nxt[k];
                end
                if (dec_point) begin
                    dec_cnt   <= '0;
                    r_latched <= r_eff;
                    if (state == S_ACCUMULATE) begin
                        snapshot <= integ_nxt[STAGES-1];
                        comb_idx <= '0;
                    end else begin
                        overrun_o <= 1'b1;
                    end
                end else begin
                    dec_cnt <= dec_cnt + DECIM_WIDTH'(1);
                end
            end
            if (state == S_COMB) begin
                comb_dly[comb_idx] <= snapshot;
                snapshot           <= snapshot - comb_dly[comb_idx];
                comb_idx           <= comb_idx + CIDX_WIDTH'(1);
            end
            if (state == S_SCALE) begin
                pcm_sample_o <= sat;
                pcm_valid_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator: stimulus queues expected samples and output cycles,
// a negedge monitor pops and compares them whenever pcm_valid_o is seen.
module tb_pdm_cic_decimator;

    localparam int unsigned LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  decim;
    logic [15:0] gain;
    logic        pdm_valid;
    logic        pdm_bit;
    logic [15:0] pcm_sample;
    logic        pcm_valid;
    logic        busy;
    logic        overrun;

    typedef struct {
        logic        chk;
        logic [15:0] val;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] ev [8];
    logic        ec [8];
    int          checks    = 0;
    int          errors    = 0;
    int unsigned cyc       = 0;
    int          ovr_cnt   = 0;
    int          valid_cnt = 0;

    pdm_cic_decimator dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .enable_i            (enable),
        .decimation_factor_i (decim),
        .gain_i              (gain),
        .pdm_valid_i         (pdm_valid),
        .pdm_bit_i           (pdm_bit),
        .pcm_sample_o        (pcm_sample),
        .pcm_valid_o         (pcm_valid),
        .busy_o              (busy),
        .overrun_o           (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (pcm_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample %h at cycle %0d, none expected", pcm_sample, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL latency: valid at cycle %0d, expected cycle %0d", cyc, mon_e.cyc);
                end
                if (mon_e.chk) begin
                    checks++;
                    if (pcm_sample !== mon_e.val) begin
                        errors++;
                        $display("FAIL sample: got %h expected %h at cycle %0d", pcm_sample, mon_e.val, cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flush the core, load new settings, then enable so strobes start in ACCUMULATE
    task automatic start_case(input logic [7:0] d, input logic [15:0] g);
        enable = 1'b0;
        decim  = d;
        gain   = g;
        tick();
        tick();
        enable = 1'b1;
        tick();
    endtask

    // pat: 0 = all ones, 1 = all zeros, 2 = alternating starting with one
    task automatic strobes(input int r_eff, input int pat, input int stride,
                           input int npts, input int cap_every);
        int pt  = 0;
        int cap = 0;
        for (int s = 0; s < r_eff * npts; s++) begin
            pdm_bit   = (pat == 0) ? 1'b1 : (pat == 1) ? 1'b0 : ((s % 2) == 0);
            pdm_valid = 1'b1;
            if ((s % r_eff) == r_eff - 1) begin
                if ((pt % cap_every) == 0 && cap < 8) begin
                    exp_q.push_back('{chk: ec[cap], val: ev[cap], cyc: cyc + LAT});
                    cap++;
                end
                pt++;
            end
            tick();
            if (stride > 1) begin
                pdm_valid = 1'b0;
                repeat (stride - 1) tick();
            end
        end
        pdm_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (20) tick();
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    int ovr0;
    int val0;

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        decim     = 8'd64;
        gain      = 16'h1000;
        pdm_valid = 1'b0;
        pdm_bit   = 1'b0;
        repeat (3) tick();
        chk("reset_sample",  32'(pcm_sample), 32'd0);
        chk("reset_valid",   32'(pcm_valid),  32'd0);
        chk("reset_busy",    32'(busy),       32'd0);
        chk("reset_overrun", 32'(overrun),    32'd0);
        rst = 1'b0;

        // Ones at R=64: fill transients 187, 2111, then 0x1000
        ev = '{16'h00BB, 16'h083F, 16'h0, 16'h0, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        ec = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ovr0 = ovr_cnt;
        start_case(8'd64, 16'h1000);
        strobes(64, 0, 4, 8, 1);
        drain("ones_r64");
        chk("ones_r64_overrun", 32'(ovr_cnt - ovr0), 32'd0);

        // Zeros at R=64: floor of the negated transients, then -4096
        ev = '{16'hFF44, 16'hF7C0, 16'h0, 16'h0, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        start_case(8'd64, 16'h1000);
        strobes(64, 1, 4, 8, 1);
        drain("zeros_r64");

        ec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        start_case(8'd64, 16'hFFFF);
        strobes(64, 0, 4, 8, 1);
        drain("sat_pos");
        ev = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        start_case(8'd64, 16'hFFFF);
        strobes(64, 1, 4, 8, 1);
        drain("sat_neg");

        // Alternating bits, odd R: comb output settles to +/-1, scaled to 0 / -1
        ev = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        ovr0 = ovr_cnt;
        start_case(8'd255, 16'h1000);
        strobes(255, 2, 2, 8, 1);
        drain("alt_r255");
        chk("alt_r255_overrun", 32'(ovr_cnt - ovr0), 32'd0);

        // R=1 clamps to 2, strobe every clock: only every 4th point is taken (snapshots 8 apart)
        ev = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        ovr0 = ovr_cnt;
        val0 = valid_cnt;
        start_case(8'd1, 16'h1000);
        strobes(2, 0, 1, 32, 4);
        drain("r1_overrun");
        chk("r1_overrun_count", 32'(ovr_cnt - ovr0), 32'd24);
        chk("r1_valid_count",   32'(valid_cnt - val0), 32'd8);

        // Drop enable in the middle of COMB: sample aborted, then restart without another flush
        start_case(8'd64, 16'h1000);
        val0 = valid_cnt;
        for (int s = 0; s < 64; s++) begin
            pdm_bit   = 1'b1;
            pdm_valid = 1'b1;
            tick();
            pdm_valid = 1'b0;
            if (s < 63) repeat (3) tick();
        end
        tick();
        chk("abort_busy_in_comb", 32'(busy), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort_busy_cleared", 32'(busy),       32'd0);
        chk("abort_sample_zero",  32'(pcm_sample), 32'd0);
        repeat (12) tick();
        chk("abort_no_valid", 32'(valid_cnt - val0), 32'd0);
        ev = '{16'h00BB, 16'h083F, 16'h0, 16'h0, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        ec = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        enable = 1'b1;
        tick();
        strobes(64, 0, 4, 8, 1);
        drain("reenable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
